// File: rtl/icache_repl_sel.sv
// Refill-victim way selector: invalid-way preference, lock mask, LFSR or round-robin policy.
// Latency: one cycle from sampled req_i to registered gnt_o/way_o/way_oh_o/err_o.
// Backpressure: none; accepts a request every cycle and returns exactly one grant per request.
module icache_repl_sel #(
  parameter int N_WAY  = 4,
  parameter int LFSR_W = 8,
  localparam int WAY_W = $clog2(N_WAY)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mode_i,
  input  logic              req_i,
  input  logic [N_WAY-1:0]  valid_i,
  input  logic [N_WAY-1:0]  lock_i,
  input  logic              seed_we_i,
  input  logic [LFSR_W-1:0] seed_i,
  output logic              gnt_o,
  output logic [WAY_W-1:0]  way_o,
  output logic [N_WAY-1:0]  way_oh_o,
  output logic              err_o
);

  // Feedback tap positions for the two supported LFSR widths.
  localparam int TAP_A = (LFSR_W == 16) ? 15 : 7;
  localparam int TAP_B = (LFSR_W == 16) ? 14 : 3;
  localparam int TAP_C = (LFSR_W == 16) ? 12 : 2;
  localparam int TAP_D = (LFSR_W == 16) ? 3  : 1;

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [WAY_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              gnt_q;
  logic [WAY_W-1:0]  way_q;
  logic [N_WAY-1:0]  way_oh_q;
  logic              err_q;

  logic              all_locked;
  logic              free_found;
  logic [WAY_W-1:0]  free_way;
  logic [WAY_W-1:0]  cand;
  logic [WAY_W-1:0]  idx;
  logic              scan_found;
  logic [WAY_W-1:0]  scan_way;
  logic              policy;
  logic [WAY_W-1:0]  sel_way;
  logic [N_WAY-1:0]  sel_oh;

  // XNOR feedback, shift left; all-ones is the lockup state, so all-zero is a legal start.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    logic fb;
    fb = ~(s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D]);
    return {s[LFSR_W-2:0], fb};
  endfunction

  // Victim choice: all-locked error, else lowest free invalid way, else policy candidate with locked-way skip.
  always_comb begin
    all_locked = &lock_i;
    free_found = 1'b0;
    free_way   = '0;
    for (int i = 0; i < N_WAY; i++) begin
      if (!free_found && !valid_i[i] && !lock_i[i]) begin
        free_found = 1'b1;
        free_way   = WAY_W'(i);
      end
    end

    cand       = mode_i ? rr_ptr_q : lfsr_q[WAY_W-1:0];
    idx        = '0;
    scan_found = 1'b0;
    scan_way   = cand;
    // N_WAY is a power of two, so the WAY_W-bit add wraps naturally.
    for (int i = 0; i < N_WAY; i++) begin
      idx = cand + WAY_W'(i);
      if (!scan_found && !lock_i[idx]) begin
        scan_found = 1'b1;
        scan_way   = idx;
      end
    end

    policy  = !all_locked && !free_found;
    sel_way = all_locked ? '0 : (free_found ? free_way : scan_way);
    sel_oh  = all_locked ? '0 : (N_WAY'(1) << sel_way);
  end

  // Next policy state: only the active mode advances, and a seed write overrides any advance.
  always_comb begin
    lfsr_d   = lfsr_q;
    rr_ptr_d = rr_ptr_q;
    if (req_i && policy && !mode_i) begin
      lfsr_d = lfsr_step(lfsr_q);
    end
    if (req_i && policy && mode_i) begin
      rr_ptr_d = sel_way + WAY_W'(1);
    end
    if (seed_we_i) begin
      lfsr_d = (&seed_i) ? '0 : seed_i;
    end
  end

  // Register policy state and the grant; reset drops any in-flight grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q   <= '0;
      rr_ptr_q <= '0;
      gnt_q    <= 1'b0;
      way_q    <= '0;
      way_oh_q <= '0;
      err_q    <= 1'b0;
    end else begin
      lfsr_q   <= lfsr_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= req_i;
      if (req_i) begin
        way_q    <= sel_way;
        way_oh_q <= sel_oh;
        err_q    <= all_locked;
      end
    end
  end

  assign gnt_o    = gnt_q;
  assign way_o    = way_q;
  assign way_oh_o = way_oh_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_icache_repl_sel.sv
// Directed bench for icache_repl_sel: 4-way/8-bit instance for the feature tests,
// 16-way/16-bit instance run against a reference LFSR model.
// Inputs change #1 after the rising edge; outputs are checked there too.
module tb_icache_repl_sel;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 4-way, 8-bit LFSR instance
  logic       rst_a, mode_a, req_a, seed_we_a;
  logic [3:0] valid_a, lock_a;
  logic [7:0] seed_a;
  logic       gnt_a, err_a;
  logic [1:0] way_a;
  logic [3:0] oh_a;

  // 16-way, 16-bit LFSR instance
  logic        rst_b, mode_b, req_b, seed_we_b;
  logic [15:0] valid_b, lock_b;
  logic [15:0] seed_b;
  logic        gnt_b, err_b;
  logic [3:0]  way_b;
  logic [15:0] oh_b;

  icache_repl_sel #(.N_WAY(4), .LFSR_W(8)) u_a (
    .clk_i(clk), .rst_i(rst_a), .mode_i(mode_a), .req_i(req_a),
    .valid_i(valid_a), .lock_i(lock_a), .seed_we_i(seed_we_a), .seed_i(seed_a),
    .gnt_o(gnt_a), .way_o(way_a), .way_oh_o(oh_a), .err_o(err_a)
  );

  icache_repl_sel #(.N_WAY(16), .LFSR_W(16)) u_b (
    .clk_i(clk), .rst_i(rst_b), .mode_i(mode_b), .req_i(req_b),
    .valid_i(valid_b), .lock_i(lock_b), .seed_we_i(seed_we_b), .seed_i(seed_b),
    .gnt_o(gnt_b), .way_o(way_b), .way_oh_o(oh_b), .err_o(err_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model of the 16-bit XNOR LFSR, taps 15,14,12,3.
  function automatic logic [15:0] ref16(input logic [15:0] s);
    logic fb;
    fb = ~(s[15] ^ s[14] ^ s[12] ^ s[3]);
    return {s[14:0], fb};
  endfunction

  logic [1:0]  exp_way  [5];
  logic [7:0]  exp_lfsr [5];
  logic [1:0]  rr_way   [5];
  logic [1:0]  rrl_way  [4];
  logic [15:0] model;

  initial begin
    exp_way  = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd1};
    exp_lfsr = '{8'h00, 8'h01, 8'h03, 8'h06, 8'h0D};
    rr_way   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    rrl_way  = '{2'd0, 2'd2, 2'd3, 2'd0};

    rst_a = 1'b1; mode_a = 1'b0; req_a = 1'b0; seed_we_a = 1'b0;
    valid_a = 4'hF; lock_a = 4'h0; seed_a = 8'h00;
    rst_b = 1'b1; mode_b = 1'b0; req_b = 1'b0; seed_we_b = 1'b0;
    valid_b = 16'hFFFF; lock_b = 16'h0000; seed_b = 16'h0000;

    // Reset state
    step(); step();
    chk("rst_gnt",  32'(gnt_a), 32'd0);
    chk("rst_way",  32'(way_a), 32'd0);
    chk("rst_oh",   32'(oh_a),  32'd0);
    chk("rst_err",  32'(err_a), 32'd0);
    chk("rst_lfsr", 32'(u_a.lfsr_q), 32'd0);
    rst_a = 1'b0;

    // LFSR sequence, 5 back-to-back requests
    req_a = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("lfsr_state", 32'(u_a.lfsr_q), 32'(exp_lfsr[k]));
      step();
      chk("lfsr_gnt", 32'(gnt_a), 32'd1);
      chk("lfsr_way", 32'(way_a), 32'(exp_way[k]));
      chk("lfsr_oh",  32'(oh_a),  32'd1 << exp_way[k]);
    end
    req_a = 1'b0;
    step();
    chk("idle_gnt", 32'(gnt_a), 32'd0);
    chk("idle_way_hold", 32'(way_a), 32'd1);

    // Invalid-way preference (lfsr now 0x1B, candidate 3)
    req_a = 1'b1; valid_a = 4'b1011;
    step();
    chk("inv_way", 32'(way_a), 32'd2);
    chk("inv_oh",  32'(oh_a),  32'b0100);
    valid_a = 4'hF;
    step();
    chk("inv_noadv_way", 32'(way_a), 32'd3);

    // Lock skip: seed lfsr to 0x03 so the candidate is way 3
    req_a = 1'b0; seed_we_a = 1'b1; seed_a = 8'h03;
    step();
    seed_we_a = 1'b0;
    chk("seed03", 32'(u_a.lfsr_q), 32'h03);
    req_a = 1'b1; lock_a = 4'b1000;
    step();
    chk("lock_skip_way", 32'(way_a), 32'd0);
    lock_a = 4'b1111;
    step();
    chk("all_lock_err", 32'(err_a), 32'd1);
    chk("all_lock_oh",  32'(oh_a),  32'd0);
    chk("all_lock_gnt", 32'(gnt_a), 32'd1);
    chk("all_lock_way", 32'(way_a), 32'd0);
    chk("all_lock_lfsr", 32'(u_a.lfsr_q), 32'h06);
    lock_a = 4'b0000;
    step();
    chk("after_lock_way", 32'(way_a), 32'd2);
    chk("after_lock_err", 32'(err_a), 32'd0);

    // Round-robin from reset
    req_a = 1'b0; rst_a = 1'b1;
    step();
    rst_a = 1'b0; mode_a = 1'b1; req_a = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("rr_way", 32'(way_a), 32'(rr_way[k]));
    end
    // Mode 0 once (lfsr 0 -> way 0), then back to mode 1: rr resumes at 1
    mode_a = 1'b0;
    step();
    chk("rr_sw_lfsr_way", 32'(way_a), 32'd0);
    mode_a = 1'b1;
    step();
    chk("rr_resume_way", 32'(way_a), 32'd1);

    // Round-robin with way 1 locked
    req_a = 1'b0; rst_a = 1'b1;
    step();
    rst_a = 1'b0; lock_a = 4'b0010; req_a = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rr_lock_way", 32'(way_a), 32'(rrl_way[k]));
    end
    lock_a = 4'b0000;

    // Seed handling: all-ones seed loads as zero
    mode_a = 1'b0; req_a = 1'b0; seed_we_a = 1'b1; seed_a = 8'hFF;
    step();
    seed_we_a = 1'b0;
    chk("seedFF_lfsr", 32'(u_a.lfsr_q), 32'h00);
    req_a = 1'b1;
    step();
    chk("seedFF_way", 32'(way_a), 32'd0);
    // Seed with concurrent request: grant from old state 0x01, then 0x06
    seed_we_a = 1'b1; seed_a = 8'h06;
    step();
    seed_we_a = 1'b0;
    chk("seed_old_way", 32'(way_a), 32'd1);
    chk("seed_loaded", 32'(u_a.lfsr_q), 32'h06);
    step();
    chk("seed_new_way", 32'(way_a), 32'd2);

    // Reset with a request in flight: grant suppressed, outputs zero
    rst_a = 1'b1;
    step();
    chk("rst_req_gnt", 32'(gnt_a), 32'd0);
    chk("rst_req_way", 32'(way_a), 32'd0);
    chk("rst_req_oh",  32'(oh_a),  32'd0);
    chk("rst_req_err", 32'(err_a), 32'd0);
    rst_a = 1'b0; req_a = 1'b0;

    // 16-way / 16-bit against the reference model
    rst_b = 1'b0; req_b = 1'b1; model = 16'h0000;
    for (int k = 0; k < 1000; k++) begin
      step();
      chk("b_gnt", 32'(gnt_b), 32'd1);
      chk("b_way", 32'(way_b), 32'(model[3:0]));
      model = ref16(model);
    end
    req_b = 1'b0;
    step();
    chk("b_idle_gnt", 32'(gnt_b), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/icache_repl_sel.md
# icache_repl_sel

Parametrised refill-victim selector for the set-associative instruction cache, replacing the fixed 4-way, 8-bit LFSR way picker. Supported configurations are 2 to 16 ways and a 16-bit LFSR option. It adds a round-robin mode, a preference for invalid ways, a per-way lock mask and a software-loadable seed. Each refill request gets a registered grant one cycle later. The cache refill controller consumes that grant when it writes the returning line.

## Interface
- N_WAY, 4, number of ways; power of two, 2..16.
- LFSR_W, 8, LFSR width; 8 or 16 only.
- WAY_W, $clog2(N_WAY), derived way-index width; not overridable.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- mode_i  in  1  0 = LFSR pseudo-random, 1 = round-robin.
- req_i  in  1  refill request; sampled every cycle.
- valid_i  in  N_WAY  valid bits of the indexed set; sampled with req_i.
- lock_i  in  N_WAY  1 = way excluded from replacement; sampled with req_i.
- seed_we_i  in  1  load LFSR state from seed_i.
- seed_i  in  LFSR_W  seed value.
- gnt_o  out  1  one-cycle pulse; way_o/way_oh_o/err_o valid for this grant.
- way_o  out  WAY_W  selected victim way; held until the next grant.
- way_oh_o  out  N_WAY  one-hot of way_o; all-zero when err_o=1.
- err_o  out  1  grant carries no usable way because all ways are locked.

## Operation
- LFSR state `lfsr` uses XNOR feedback, shift left, with the new bit entering at bit 0.
  - Taps for LFSR_W=8: bits 7,3,2,1.
  - Taps for LFSR_W=16: bits 15,14,12,3.
  - All-ones is the lockup state. A seed of all ones is loaded as all zeros.
- Round-robin pointer `rr_ptr` is WAY_W bits wide.
- Selection is evaluated on the sampled req_i cycle, in priority order:
  1. If all ways are locked (lock_i all ones): err_o=1, way_o=0, way_oh_o=0. Neither lfsr nor rr_ptr changes.
  2. If any way is unlocked and invalid: choose the lowest-index way with !valid_i & !lock_i. Neither lfsr nor rr_ptr changes.
  3. Otherwise pick a policy candidate.
     - The candidate is lfsr[WAY_W-1:0] in mode 0, or rr_ptr in mode 1.
     - If the candidate is locked, scan upward with wrap-around and take the first unlocked way.
     - Mode 0: lfsr advances one step.
     - Mode 1: rr_ptr = chosen+1 modulo N_WAY, wrapping from N_WAY-1 to 0.
- Only the active mode's state advances. Switching mode preserves both lfsr and rr_ptr.
- seed_we_i loads lfsr on the next edge.
  - It takes priority over an advance in the same cycle.
  - A selection made in that cycle uses the old lfsr value.
- Back-to-back requests every cycle are supported, with one grant per request and no bubbles.

## Timing
- Reset values: lfsr=0, rr_ptr=0, gnt_o=0, way_o=0, way_oh_o=0, err_o=0.
- Reset timing: a request presented in the same cycle as rst_i is dropped. A reset between a request and its grant suppresses the grant.
- Grant latency: req_i high at edge N gives gnt_o high for the cycle after edge N.
  - way_o, way_oh_o and err_o update at that same edge.
  - All outputs are registered, with no combinational input-to-output path.
- gnt_o is low in every cycle that has no preceding request. way_o and way_oh_o hold their last values.
- valid_i and lock_i matter only in cycles where req_i=1.

## Test plan
- LFSR sequence: reset, then N_WAY=4, LFSR_W=8, mode 0, valid all ones, lock 0, and 5 back-to-back requests.
  - Required: way_o = 0,1,3,2,1 with lfsr = 0x00,0x01,0x03,0x06,0x0D before each grant.
  - Required: gnt_o high on 5 consecutive cycles, starting one cycle after the first request.
- Invalid preference: valid_i=4'b1011, lock 0.
  - Required: way_o=2, way_oh_o=4'b0100.
  - Required: the next all-valid request gives the same way as it would have without this request, showing lfsr did not advance.
- Lock skip: lfsr=0x03 (candidate 3), lock_i=4'b1000, all valid.
  - Required: way_o=0.
  - Required: lock_i=4'b1111 gives err_o=1, way_oh_o=0, gnt_o=1, and no state advance.
- Round-robin: mode 1, all valid.
  - With lock 0, 5 requests give way_o = 0,1,2,3,0.
  - After reset with lock_i=4'b0010, 4 requests give 0,2,3,0.
  - Switching to mode 0 and back resumes from the preserved rr_ptr.
- Seed handling:
  - seed_i=0xFF with seed_we_i, then a request, gives lfsr=0x00 and way_o=0.
  - seed_i=0x06 together with a request gives a grant from the old state. The next request then gives way_o=2.
- Reset and parameters:
  - rst_i asserted between request and grant gives no grant and all outputs zero.
  - Repeat the LFSR sequence test with N_WAY=16, LFSR_W=16 and check that way_o equals lfsr[3:0] against a reference model over 1000 requests.
